// File: rtl/uart_rx_fifo.sv
// Receive character FIFO that sits between the UART receiver and the register front end.
// The oldest entry is shown first-word-fall-through. The block also reports level,
// overrun, threshold and idle-timeout status.
module uart_rx_fifo #(
  parameter int unsigned DATA_UART  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = $clog2(FIFO_DEPTH),
  parameter int unsigned TO_W       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 clear_i,
  input  logic [DATA_UART-1:0] rx_data_i,
  input  logic                 rx_valid_i,
  input  logic                 rd_en_i,
  output logic [DATA_UART-1:0] rd_data_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic [ADDR_W:0]      count_o,
  input  logic [ADDR_W:0]      thresh_i,
  output logic                 thresh_o,
  output logic                 overrun_o,
  input  logic                 overrun_clr_i,
  input  logic [TO_W-1:0]      timeout_cycles_i,
  output logic                 timeout_o
);

  localparam logic [ADDR_W:0] FullCount = (ADDR_W+1)'(FIFO_DEPTH);

  logic [DATA_UART-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]      count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;

  logic empty, full;
  logic push, pop, push_ok, drop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FullCount);

  assign push    = rx_valid_i & en_i & ~clear_i;
  assign pop     = rd_en_i & ~empty & ~clear_i;
  // A push into a full FIFO still lands if a pop frees the head slot in the same cycle.
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  // Next-state for pointers, occupancy, overrun flag and idle timer.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    to_cnt_d  = to_cnt_q;

    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      unique case ({push_ok, pop})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end

    // A new drop takes priority over a clear request issued in the same cycle.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (overrun_clr_i) begin
      overrun_d = 1'b0;
    end

    if (push || pop || clear_i || empty || (timeout_cycles_i == '0)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q < timeout_cycles_i) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end else begin
      to_cnt_d = timeout_cycles_i;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // Storage array write port; contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= rx_data_i;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    rd_data_o = empty ? '0 : mem_q[rd_ptr_q];
    empty_o   = empty;
    full_o    = full;
    count_o   = count_q;
    thresh_o  = (thresh_i != '0) && (count_q >= thresh_i);
    overrun_o = overrun_q;
    timeout_o = (timeout_cycles_i != '0) && (to_cnt_q == timeout_cycles_i) && !empty;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        en_i;
  logic        clear_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rd_en_i;
  logic [7:0]  rd_data_o;
  logic        empty_o;
  logic        full_o;
  logic [4:0]  count_o;
  logic [4:0]  thresh_i;
  logic        thresh_o;
  logic        overrun_o;
  logic        overrun_clr_i;
  logic [15:0] timeout_cycles_i;
  logic        timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(
    .DATA_UART  (8),
    .FIFO_DEPTH (16),
    .TO_W       (16)
  ) u_dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .en_i             (en_i),
    .clear_i          (clear_i),
    .rx_data_i        (rx_data_i),
    .rx_valid_i       (rx_valid_i),
    .rd_en_i          (rd_en_i),
    .rd_data_o        (rd_data_o),
    .empty_o          (empty_o),
    .full_o           (full_o),
    .count_o          (count_o),
    .thresh_i         (thresh_i),
    .thresh_o         (thresh_o),
    .overrun_o        (overrun_o),
    .overrun_clr_i    (overrun_clr_i),
    .timeout_cycles_i (timeout_cycles_i),
    .timeout_o        (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check_eq(tag, {24'd0, rd_data_o}, {24'd0, exp});
    rd_en_i = 1'b1;
    tick();
    rd_en_i = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rd_data"}, {24'd0, rd_data_o}, 32'd0);
    check_eq({tag, "_empty"},   {31'd0, empty_o},   32'd1);
    check_eq({tag, "_full"},    {31'd0, full_o},    32'd0);
    check_eq({tag, "_count"},   {27'd0, count_o},   32'd0);
    check_eq({tag, "_thresh"},  {31'd0, thresh_o},  32'd0);
    check_eq({tag, "_overrun"}, {31'd0, overrun_o}, 32'd0);
    check_eq({tag, "_timeout"}, {31'd0, timeout_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; en_i = 1'b1; clear_i = 1'b0; rx_data_i = '0; rx_valid_i = 1'b0;
    rd_en_i = 1'b0; thresh_i = '0; overrun_clr_i = 1'b0; timeout_cycles_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    check_reset_vals("reset");

    // Basic ordering.
    push(8'h41); push(8'h42); push(8'h43);
    check_eq("basic_count", {27'd0, count_o}, 32'd3);
    check_eq("basic_head", {24'd0, rd_data_o}, 32'h41);
    pop_check("basic_pop0", 8'h41);
    pop_check("basic_pop1", 8'h42);
    pop_check("basic_pop2", 8'h43);
    check_eq("basic_empty", {31'd0, empty_o}, 32'd1);
    check_eq("basic_zero", {24'd0, rd_data_o}, 32'd0);

    // Wrap-around.
    for (int i = 0; i < 16; i++) push(8'(i));
    check_eq("wrap_full", {31'd0, full_o}, 32'd1);
    check_eq("wrap_count16", {27'd0, count_o}, 32'd16);
    for (int i = 0; i < 8; i++) pop_check("wrap_pop_a", 8'(i));
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    for (int i = 0; i < 16; i++) pop_check("wrap_pop_b", 8'(8'h08 + i));
    check_eq("wrap_empty", {31'd0, empty_o}, 32'd1);

    // Overrun.
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    push(8'hAA);
    check_eq("ovr_set", {31'd0, overrun_o}, 32'd1);
    check_eq("ovr_head", {24'd0, rd_data_o}, 32'h20);
    check_eq("ovr_count", {27'd0, count_o}, 32'd16);
    overrun_clr_i = 1'b1;
    push(8'hBB);
    overrun_clr_i = 1'b0;
    check_eq("ovr_set_wins", {31'd0, overrun_o}, 32'd1);
    overrun_clr_i = 1'b1;
    tick();
    overrun_clr_i = 1'b0;
    check_eq("ovr_cleared", {31'd0, overrun_o}, 32'd0);

    // Full with simultaneous push and pop.
    rx_data_i = 8'h55; rx_valid_i = 1'b1; rd_en_i = 1'b1;
    tick();
    rx_valid_i = 1'b0; rd_en_i = 1'b0;
    check_eq("fullpp_count", {27'd0, count_o}, 32'd16);
    check_eq("fullpp_ovr", {31'd0, overrun_o}, 32'd0);
    check_eq("fullpp_head", {24'd0, rd_data_o}, 32'h21);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    check_eq("clear_empty", {31'd0, empty_o}, 32'd1);

    // Empty with push and rd_en together; then disabled push.
    rx_data_i = 8'h66; rx_valid_i = 1'b1; rd_en_i = 1'b1;
    tick();
    rx_valid_i = 1'b0; rd_en_i = 1'b0;
    check_eq("emptypp_count", {27'd0, count_o}, 32'd1);
    check_eq("emptypp_data", {24'd0, rd_data_o}, 32'h66);
    en_i = 1'b0;
    push(8'h77);
    en_i = 1'b1;
    check_eq("dis_count", {27'd0, count_o}, 32'd1);
    check_eq("dis_ovr", {31'd0, overrun_o}, 32'd0);
    pop_check("dis_pop", 8'h66);
    check_eq("dis_empty", {31'd0, empty_o}, 32'd1);

    // Threshold and idle timeout.
    thresh_i = 5'd4; timeout_cycles_i = 16'd10;
    push(8'h01); push(8'h02); push(8'h03);
    check_eq("thr_below", {31'd0, thresh_o}, 32'd0);
    push(8'h04);
    check_eq("thr_hit", {31'd0, thresh_o}, 32'd1);
    check_eq("to_early0", {31'd0, timeout_o}, 32'd0);
    for (int i = 0; i < 9; i++) tick();
    check_eq("to_early9", {31'd0, timeout_o}, 32'd0);
    tick();
    check_eq("to_hit", {31'd0, timeout_o}, 32'd1);
    tick(); tick();
    check_eq("to_hold", {31'd0, timeout_o}, 32'd1);
    pop_check("to_pop", 8'h01);
    check_eq("to_drop", {31'd0, timeout_o}, 32'd0);
    check_eq("thr_drop", {31'd0, thresh_o}, 32'd0);
    timeout_cycles_i = '0;

    // Flush with a concurrent push.
    push(8'h05); push(8'h06);
    check_eq("flush_pre", {27'd0, count_o}, 32'd5);
    clear_i = 1'b1; rx_data_i = 8'h99; rx_valid_i = 1'b1;
    tick();
    clear_i = 1'b0; rx_valid_i = 1'b0;
    check_eq("flush_count", {27'd0, count_o}, 32'd0);
    check_eq("flush_empty", {31'd0, empty_o}, 32'd1);
    check_eq("flush_data", {24'd0, rd_data_o}, 32'd0);

    // Asynchronous reset mid-stream, with overrun and threshold active.
    for (int i = 0; i < 16; i++) push(8'(8'h30 + i));
    push(8'hCC);
    check_eq("pre_rst_ovr", {31'd0, overrun_o}, 32'd1);
    check_eq("pre_rst_thr", {31'd0, thresh_o}, 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_vals("async_rst");
    tick();
    rst_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer that sits directly downstream of the UART receiver FSM. It captures each completed character, reported as a one-cycle valid pulse with a parallel data byte, into a circular FIFO. It presents the oldest character first-word-fall-through to the AXI-lite register front end. It also provides level, overrun, threshold and idle-timeout status for the interrupt logic.

## Interface
Parameters:
- DATA_UART, 8, character width in bits; matches the receiver's data width.
- FIFO_DEPTH, 16, number of entries; power of two, at least 2.
- ADDR_W, $clog2(FIFO_DEPTH), pointer width.
- TO_W, 16, idle-timeout counter width.

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- en_i  in  1  UART enable; while low, pushes are ignored and pops still work.
- clear_i  in  1  synchronous flush of FIFO contents.
- rx_data_i  in  DATA_UART  received character from the receiver.
- rx_valid_i  in  1  one-cycle strobe qualifying rx_data_i.
- rd_en_i  in  1  pop request from the register front end.
- rd_data_o  out  DATA_UART  head entry; forced to 0 when empty.
- empty_o  out  1  FIFO holds 0 entries.
- full_o  out  1  FIFO holds FIFO_DEPTH entries.
- count_o  out  ADDR_W+1  current occupancy, 0..FIFO_DEPTH.
- thresh_i  in  ADDR_W+1  interrupt level threshold; 0 disables it.
- thresh_o  out  1  level interrupt.
- overrun_o  out  1  sticky flag: a character was dropped.
- overrun_clr_i  in  1  clears overrun_o.
- timeout_cycles_i  in  TO_W  idle-timeout length in clk_i cycles; 0 disables it.
- timeout_o  out  1  data is waiting and the line has been idle.

## Operation
- Storage: circular array of FIFO_DEPTH entries, with write pointer wr_ptr and read pointer rd_ptr, each ADDR_W bits and wrapping modulo FIFO_DEPTH.
  - Occupancy is tracked in a separate count register of ADDR_W+1 bits.
  - The storage array is not reset; pointers and count are.
- push = rx_valid_i & en_i & ~clear_i.
- pop = rd_en_i & ~empty_o & ~clear_i.
- Accepted push: write mem[wr_ptr], then increment wr_ptr.
- Accepted pop: increment rd_ptr.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
- Full with push and pop in the same cycle: both take effect; no overrun.
- Full with push and no pop: the character is dropped, pointers are unchanged, and overrun_o is set.
- Empty with push and rd_en_i in the same cycle: push accepted, pop ignored; the new entry appears on rd_data_o in the next cycle.
- rd_en_i while empty: ignored, no state change, no error.
- clear_i: wr_ptr, rd_ptr and count go to 0, and the timeout counter is cleared.
  - Pushes and pops in the same cycle are discarded.
  - overrun_o is unaffected.
- overrun_o: if a set event and overrun_clr_i occur in the same cycle, set wins.
- thresh_o = (thresh_i != 0) & (count_o >= thresh_i), decoded from registered count.
- Idle timer (to_cnt, TO_W bits):
  - Cleared when a push or pop occurs, on clear_i, when empty_o is 1, or when timeout_cycles_i is 0.
  - Otherwise increments and saturates at timeout_cycles_i.
  - timeout_o = (timeout_cycles_i != 0) & (to_cnt == timeout_cycles_i) & ~empty_o.
  - Once asserted, timeout_o remains high until the next push, pop or clear.
- Reset mid-operation: all pointers, count, to_cnt and overrun are cleared immediately; contents are discarded.

## Timing
- Reset values:
  - rd_data_o = 0, empty_o = 1, full_o = 0, count_o = 0.
  - thresh_o = 0, overrun_o = 0, timeout_o = 0.
- Push latency: a character pushed at edge N is visible on rd_data_o, with empty_o = 0 and count_o updated, after edge N.
- Pop: rd_data_o is valid combinationally while empty_o = 0.
  - Asserting rd_en_i consumes the shown word at that edge.
  - The next entry is shown after the edge.
- Status outputs (empty_o, full_o, thresh_o, timeout_o) are decoded from registered state only; there is no combinational path from the *_i strobes.
- Sustained push and pop every cycle is supported at full throughput.
- overrun_o asserts the cycle after the dropped push.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 with no pops:
  - count_o = 3, rd_data_o = 0x41.
  - Three pops return 0x41, 0x42, 0x43, then empty_o = 1 and rd_data_o = 0.
- Wrap-around: with FIFO_DEPTH = 16, push 16 values 0x00..0x0F.
  - full_o = 1.
  - Pop 8, push 0x10..0x17, pop 16: the data order is 0x08..0x17.
- Overrun:
  - Fill to 16, push 0xAA: overrun_o = 1 and the head is unchanged.
  - Pulse overrun_clr_i together with another dropped push: overrun_o stays 1.
  - Clear alone: overrun_o = 0.
- Simultaneous events:
  - Full plus push plus pop: count stays 16 and no overrun.
  - Empty plus push plus rd_en_i: count = 1 and the data is retained.
  - en_i = 0 plus push: ignored with no overrun.
- Threshold and timeout, with thresh_i = 4 and timeout_cycles_i = 10:
  - After the 4th push, thresh_o = 1.
  - Ten idle cycles later, timeout_o = 1.
  - A pop drops timeout_o the next cycle.
- Flush and reset: with 5 entries, assert clear_i together with a push; the result is count = 0 and empty.
  - Assert rst_i asynchronously mid-stream: all outputs take their reset values before the next edge.
